// File: rtl/vending_pkg.sv
// Shared definitions for the vending front end: keypad code map, debounce
// state encoding and a scan-order helper.
package vending_pkg;

    // Debounce FSM states.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_PEND   = 2'd1,
        HELD         = 2'd2,
        RELEASE_PEND = 2'd3
    } debounce_state_t;

    // Key code per position, indexed {col[1:0], row[1:0]} (row 0 = top row).
    localparam logic [15:0][3:0] KEYMAP = {
        4'hD, 4'hC, 4'hB, 4'hA,   // column 3, rows 3..0
        4'hE, 4'h9, 4'h6, 4'h3,   // column 2, rows 3..0
        4'hF, 4'h8, 4'h5, 4'h2,   // column 1, rows 3..0
        4'h0, 4'h7, 4'h4, 4'h1    // column 0, rows 3..0
    };

    // Index of the first active position in scan order (lowest column, then
    // lowest row). Returns 0 when nothing is active; callers qualify that case.
    function automatic logic [3:0] first_pos(input logic [15:0] i_pos);
        logic [3:0] v_idx;
        v_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (i_pos[i]) v_idx = 4'(i);
        end
        return v_idx;
    endfunction

endpackage

// File: rtl/keypad_col_scan.sv
// Column scanner: drives one column low at a time, synchronises the row
// inputs and collects one 16-bit position vector per four-column frame.
// o_frame_done is high on the last cycle of the column-3 dwell, when o_pos
// holds the complete frame (column 3 taken straight from the synchroniser).
module keypad_col_scan #(
    parameter int SCAN_CYCLES = 100000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [3:0]  i_row,
    output logic [3:0]  o_col,
    output logic        o_frame_done,
    output logic [15:0] o_pos
);

    localparam int unsigned DW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);

    generate
        if (SCAN_CYCLES < 4) begin : g_bad_scan_cycles
            $error("keypad_col_scan: SCAN_CYCLES must be at least 4");
        end
    endgenerate

    logic [3:0]    r_row_meta;
    logic [3:0]    r_row_sync;
    logic [DW-1:0] r_dwell_cnt;
    logic [1:0]    r_col_idx;
    logic [3:0]    r_col;
    logic [11:0]   r_pos_lo;

    logic          w_dwell_last;
    logic [3:0]    w_row_act;

    assign w_dwell_last = (r_dwell_cnt == DWELL_LAST);
    assign w_row_act    = ~r_row_sync;   // rows are active-low

    // Two-flop synchroniser for the asynchronous row inputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_row_meta <= 4'h0;
            r_row_sync <= 4'h0;
        end else begin
            r_row_meta <= i_row;
            r_row_sync <= r_row_meta;
        end
    end

    // Dwell counter and column rotation; COL is kept as its own register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dwell_cnt <= '0;
            r_col_idx   <= 2'd0;
            r_col       <= 4'b1110;
        end else if (w_dwell_last) begin
            r_dwell_cnt <= '0;
            r_col_idx   <= r_col_idx + 2'd1;
            r_col       <= {r_col[2:0], r_col[3]};
        end else begin
            r_dwell_cnt <= r_dwell_cnt + DW'(1);
        end
    end

    // Capture columns 0..2 on their last dwell cycle, once the synchroniser has settled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pos_lo <= 12'h000;
        end else if (w_dwell_last) begin
            case (r_col_idx)
                2'd0:    r_pos_lo[3:0]  <= w_row_act;
                2'd1:    r_pos_lo[7:4]  <= w_row_act;
                2'd2:    r_pos_lo[11:8] <= w_row_act;
                default: r_pos_lo       <= r_pos_lo;
            endcase
        end
    end

    assign o_col        = r_col;
    assign o_frame_done = w_dwell_last && (r_col_idx == 2'd3);
    assign o_pos        = {w_row_act, r_pos_lo};

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad front end: column scan, per-frame key resolution and a
// frame-rate debounce FSM producing KEY_PRESS, KEY_STROBE and a held ITEM_CODE.
// Build option: define KEYPAD_MULTIKEY_REJECT_EN to treat chorded frames as
// empty; otherwise a chord resolves to its first key in scan order.
module keypad_scanner
    import vending_pkg::*;
#(
    parameter int SCAN_CYCLES     = 100000,
    parameter int DEBOUNCE_FRAMES = 5
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic [3:0]      ROW,
    output logic [3:0]      COL,
    output logic [3:0]      ITEM_CODE,
    output logic            KEY_PRESS,
    output logic            KEY_STROBE,
    output debounce_state_t o_dbg_state
);

    localparam int unsigned   CW         = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CW-1:0] CNT_TARGET = CW'(DEBOUNCE_FRAMES);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam bit            SINGLE     = (DEBOUNCE_FRAMES == 1);

    generate
        if (DEBOUNCE_FRAMES < 1) begin : g_bad_debounce_frames
            $error("keypad_scanner: DEBOUNCE_FRAMES must be at least 1");
        end
    endgenerate

    logic            w_frame_done;
    logic [15:0]     w_pos;
    logic [4:0]      w_num_active;
    logic            w_is_key;
    logic [3:0]      w_key_code;
    logic            w_same;

    debounce_state_t r_state, w_state_nxt;
    logic [3:0]      r_cand,  w_cand_nxt;
    logic [CW-1:0]   r_cnt,   w_cnt_nxt;
    logic [3:0]      r_item,  w_item_nxt;
    logic            r_press, w_press_nxt;
    logic            r_strobe, w_strobe_nxt;

    keypad_col_scan #(
        .SCAN_CYCLES (SCAN_CYCLES)
    ) u_col_scan (
        .i_clk        (CLK),
        .i_rst_n      (RESET_N),
        .i_row        (ROW),
        .o_col        (COL),
        .o_frame_done (w_frame_done),
        .o_pos        (w_pos)
    );

    // Frame resolution: NONE / KEY(code); a chord is either rejected or
    // reduced to its first position in scan order.
    assign w_num_active = 5'($countones(w_pos));
`ifdef KEYPAD_MULTIKEY_REJECT_EN
    assign w_is_key     = (w_num_active == 5'd1);
`else
    assign w_is_key     = (w_num_active != 5'd0);
`endif
    assign w_key_code   = KEYMAP[first_pos(w_pos)];
    assign w_same       = w_is_key && (w_key_code == r_cand);

    // Debounce next-state logic, advanced only on frame results.
    always_comb begin
        w_state_nxt  = r_state;
        w_cand_nxt   = r_cand;
        w_cnt_nxt    = r_cnt;
        w_item_nxt   = r_item;
        w_press_nxt  = r_press;
        w_strobe_nxt = 1'b0;
        if (w_frame_done) begin
            case (r_state)
                IDLE: begin
                    if (w_is_key) begin
                        w_cand_nxt = w_key_code;
                        w_cnt_nxt  = CNT_ONE;
                        if (SINGLE) begin
                            w_state_nxt  = HELD;
                            w_item_nxt   = w_key_code;
                            w_press_nxt  = 1'b1;
                            w_strobe_nxt = 1'b1;
                        end else begin
                            w_state_nxt = PRESS_PEND;
                        end
                    end
                end
                PRESS_PEND: begin
                    if (!w_is_key) begin
                        w_state_nxt = IDLE;
                    end else if (w_same) begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                        if (r_cnt + CNT_ONE == CNT_TARGET) begin
                            w_state_nxt  = HELD;
                            w_item_nxt   = w_key_code;
                            w_press_nxt  = 1'b1;
                            w_strobe_nxt = 1'b1;
                        end
                    end else begin
                        w_cand_nxt = w_key_code;
                        w_cnt_nxt  = CNT_ONE;
                    end
                end
                HELD: begin
                    if (!w_same) begin
                        w_cnt_nxt = CNT_ONE;
                        if (SINGLE) begin
                            w_state_nxt = IDLE;
                            w_press_nxt = 1'b0;
                        end else begin
                            w_state_nxt = RELEASE_PEND;
                        end
                    end
                end
                RELEASE_PEND: begin
                    if (w_same) begin
                        w_state_nxt = HELD;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                        if (r_cnt + CNT_ONE == CNT_TARGET) begin
                            w_state_nxt = IDLE;
                            w_press_nxt = 1'b0;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // Debounce state and output registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state  <= IDLE;
            r_cand   <= 4'h0;
            r_cnt    <= '0;
            r_item   <= 4'h0;
            r_press  <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cand   <= w_cand_nxt;
            r_cnt    <= w_cnt_nxt;
            r_item   <= w_item_nxt;
            r_press  <= w_press_nxt;
            r_strobe <= w_strobe_nxt;
        end
    end

    assign ITEM_CODE   = r_item;
    assign KEY_PRESS   = r_press;
    assign KEY_STROBE  = r_strobe;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a behavioural keypad drives ROW from COL, frames
// are stepped one at a time, and a frame-history reference model predicts
// KEY_PRESS / ITEM_CODE / KEY_STROBE.
module tb_keypad_scanner;
    import vending_pkg::*;

    localparam int SC    = 8;
    localparam int DF    = 3;
    localparam int FRAME = 4 * SC;

    // ---------------- clock / reset ----------------
    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic [3:0]      row;
    logic [3:0]      col;
    logic [3:0]      item;
    logic            press;
    logic            strobe;
    debounce_state_t dbg_state;
    logic [15:0]     keys = 16'h0000;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_CYCLES     (SC),
        .DEBOUNCE_FRAMES (DF)
    ) dut (
        .CLK         (clk),
        .RESET_N     (rst_n),
        .ROW         (row),
        .COL         (col),
        .ITEM_CODE   (item),
        .KEY_PRESS   (press),
        .KEY_STROBE  (strobe),
        .o_dbg_state (dbg_state)
    );

    // Physical keypad: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (keys[c*4 + r] && !col[c]) row[r] = 1'b0;
    end

    // ---------------- bookkeeping ----------------
    int    n_tests = 0;
    int    n_fail  = 0;
    int    t       = 0;       // cycle position inside the current frame
    int    n_strobe_frame = 0;
    string phase   = "init";

    // Key codes as printed on the pad, [column][row].
    int code_tab [4][4] = '{'{1, 4, 7, 0}, '{2, 5, 8, 15}, '{3, 6, 9, 14}, '{10, 11, 12, 13}};

    // Reference model: history of frame results (-1 = nothing) since reset.
    int         res_q[$];
    int         m_base  = 0;     // first frame counted after the last press/release decision
    bit         m_press = 1'b0;
    logic [3:0] m_item  = 4'h0;
    logic [3:0] exp_q[$];        // scoreboard of expected strobe codes

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: got %0h expected %0h", phase, tag, got, exp);
        end
    endtask

    function automatic logic [15:0] kp(input int c, input int r);
        logic [15:0] v;
        v = 16'h0001;
        return v << (c*4 + r);
    endfunction

    // What a frame with this set of held keys means.
    function automatic int resolve(input logic [15:0] k);
        int n;
        int first;
        n = 0;
        first = -1;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (k[c*4 + r]) begin
                    n++;
                    if (first < 0) first = code_tab[c][r];
                end
`ifdef KEYPAD_MULTIKEY_REJECT_EN
        if (n > 1) return -1;
`endif
        return first;
    endfunction

    // A press is accepted when the last DF frames since the last decision
    // are the same key; a release when the last DF frames all differ from it.
    task automatic model_frame(input logic [15:0] k, output bit strobe_exp);
        int  n;
        int  last;
        bit  all_same;
        bit  none_item;
        res_q.push_back(resolve(k));
        n = res_q.size();
        strobe_exp = 1'b0;
        if (n - m_base >= DF) begin
            last      = res_q[n-1];
            all_same  = 1'b1;
            none_item = 1'b1;
            for (int i = n - DF; i < n; i++) begin
                if (res_q[i] != last) all_same = 1'b0;
                if (res_q[i] == int'(m_item)) none_item = 1'b0;
            end
            if (!m_press && last >= 0 && all_same) begin
                m_press    = 1'b1;
                m_item     = 4'(last);
                exp_q.push_back(4'(last));
                strobe_exp = 1'b1;
                m_base     = n;
            end else if (m_press && none_item) begin
                m_press = 1'b0;
                m_base  = n;
            end
        end
    endtask

    task automatic model_reset();
        res_q.delete();
        exp_q.delete();
        m_base  = 0;
        m_press = 1'b0;
        m_item  = 4'h0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        logic [3:0] ce;
        logic [3:0] pend;
        @(posedge clk);
        #1;
        t  = (t + 1) % FRAME;
        ce = 4'b0001 << (t / SC);
        ce = ~ce;
        check("col", 32'(col), 32'(ce));
        if (strobe === 1'b1) begin
            n_strobe_frame++;
            check("strobe_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                pend = exp_q.pop_front();
                check("strobe_item", 32'(item), 32'(pend));
            end
        end
    endtask

    task automatic do_frame(input logic [15:0] k);
        bit se;
        keys = k;
        n_strobe_frame = 0;
        repeat (FRAME - 1) tick();
        check("pre_press", 32'(press), 32'(m_press));
        check("pre_item", 32'(item), 32'(m_item));
        check("pre_strobes", 32'(n_strobe_frame), 32'd0);
        model_frame(k, se);
        tick();
        check("press", 32'(press), 32'(m_press));
        check("item", 32'(item), 32'(m_item));
        check("strobe", 32'(strobe), 32'(se));
    endtask

    task automatic check_reset_values();
        check("rst_col", 32'(col), 32'h0000000E);
        check("rst_press", 32'(press), 32'd0);
        check("rst_item", 32'(item), 32'd0);
        check("rst_strobe", 32'(strobe), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
    endtask

    // Assert reset asynchronously at frame position at_t, hold, release on a falling edge.
    task automatic do_reset_mid(input int at_t);
        int guard;
        guard = 0;
        while (t != at_t && guard < FRAME) begin
            tick();
            guard++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold_col", 32'(col), 32'h0000000E);
        @(negedge clk);
        rst_n = 1'b1;
        t = 0;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [15:0] cur;
        int          pick;

        // 1. reset, then reset again mid-dwell of column 2
        phase = "reset";
        #1 rst_n = 1'b0;
        #1 check_reset_values();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        do_frame(16'h0000);
        do_reset_mid(20);
        do_frame(16'h0000);

        // 2. clean press of key 5 (column 1, row 1), then release
        phase = "clean";
        repeat (10) do_frame(kp(1, 1));
        check("clean_item", 32'(item), 32'h5);
        repeat (5) do_frame(16'h0000);
        check("clean_item_held", 32'(item), 32'h5);
        check("clean_released", 32'(press), 32'd0);

        // 3. bouncing key 7 (column 0, row 2)
        phase = "bounce";
        do_frame(kp(0, 2));
        do_frame(16'h0000);
        do_frame(kp(0, 2));
        do_frame(16'h0000);
        repeat (5) do_frame(kp(0, 2));
        check("bounce_item", 32'(item), 32'h7);
        repeat (4) do_frame(16'h0000);

        // 4. key 0 held with a single empty frame inside
        phase = "glitch";
        repeat (4) do_frame(kp(0, 3));
        do_frame(16'h0000);
        check("glitch_press", 32'(press), 32'd1);
        repeat (3) do_frame(kp(0, 3));
        check("glitch_item", 32'(item), 32'h0);
        repeat (4) do_frame(16'h0000);

        // 5. chord of keys 1 and 2
        phase = "chord";
        repeat (6) do_frame(kp(0, 0) | kp(1, 0));
`ifdef KEYPAD_MULTIKEY_REJECT_EN
        check("chord_press", 32'(press), 32'd0);
`else
        check("chord_press", 32'(press), 32'd1);
        check("chord_item", 32'(item), 32'h1);
`endif
        repeat (4) do_frame(16'h0000);

        // 6. reset while key A is held; A stays down across reset
        phase = "reset_held";
        repeat (4) do_frame(kp(3, 0));
        check("held_a_press", 32'(press), 32'd1);
        do_reset_mid(13);
        repeat (2) do_frame(kp(3, 0));
        check("held_a_not_yet", 32'(press), 32'd0);
        do_frame(kp(3, 0));
        check("held_a_press2", 32'(press), 32'd1);
        check("held_a_item", 32'(item), 32'hA);
        repeat (4) do_frame(16'h0000);

        // 7. random frames: runs of the same key set, gaps, other keys, chords
        phase = "random";
        cur = 16'h0000;
        for (int f = 0; f < 60; f++) begin
            pick = int'($urandom_range(0, 99));
            if (pick < 55) cur = cur;
            else if (pick < 70) cur = 16'h0000;
            else if (pick < 92) cur = kp(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            else cur = kp(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)))
                     | kp(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            do_frame(cur);
        end
        repeat (4) do_frame(16'h0000);

        // ---------------- final report ----------------
        phase = "final";
        check("strobes_all_seen", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

- Front-end stage that scans a 4x4 matrix keypad (Pmod KYPD layout).
- Synchronises and debounces the row inputs, then drives the vending FSM's key inputs.
- Presents a debounced `KEY_PRESS` level and a held hex `ITEM_CODE`; the downstream FSM samples `ITEM_CODE` while `KEY_PRESS` is high.

## Interface
- `SCAN_CYCLES`, default 100000: clock cycles each column is driven low; minimum 4.
- `DEBOUNCE_FRAMES`, default 5: consecutive identical frame results needed to accept a press or a release; minimum 1.
- `CLK` in 1: system clock. One clock domain.
- `RESET_N` in 1: reset, asynchronous assert, active-low.
- `ROW` in 4: keypad rows, active-low, externally pulled up, asynchronous to `CLK`.
- `COL` out 4: column drive, active-low, exactly one bit low at all times.
- `ITEM_CODE` out 4: code of the last accepted key; held after release.
- `KEY_PRESS` out 1: debounced key-down level.
- `KEY_STROBE` out 1: one-cycle pulse on each accepted press.

## Operation
- **Row synchroniser:** `ROW` passes through a 2-FF synchroniser before any use.
- **Column scan:**
  - `col_idx` steps 0 to 3 and wraps; `COL` = ~(1 << `col_idx`).
  - Each column dwells `SCAN_CYCLES` cycles.
  - Synchronised rows are sampled only on the dwell's last cycle, which lets the synchroniser settle.
- **Key map:** position (column c, row r), rows top to bottom, gives these codes:
  - column 0: 1, 4, 7, 0
  - column 1: 2, 5, 8, F
  - column 2: 3, 6, 9, E
  - column 3: A, B, C, D
- **Frame:** 4 dwells, starting at column 0. The frame result is resolved on the last cycle of the column-3 dwell:
  - NONE: no active row seen.
  - KEY(code): exactly one active position.
  - MULTI: two or more active positions; see Configuration.
- **Debounce FSM**, evaluated once per frame result; `cnt` width is $clog2(`DEBOUNCE_FRAMES`+1):
  - IDLE:
    - KEY(c): cand = c, cnt = 1. Go to PRESS_PEND, or straight to HELD if `DEBOUNCE_FRAMES` == 1.
    - NONE: stay.
  - PRESS_PEND:
    - KEY(cand): cnt++. When cnt reaches `DEBOUNCE_FRAMES`, go to HELD, set `ITEM_CODE` = cand, `KEY_PRESS` = 1, pulse `KEY_STROBE`.
    - KEY(other): restart with cand = other, cnt = 1.
    - NONE: go to IDLE.
  - HELD:
    - KEY(cand): stay.
    - NONE or KEY(other): go to RELEASE_PEND, cnt = 1, or straight to IDLE if `DEBOUNCE_FRAMES` == 1.
  - RELEASE_PEND (`KEY_PRESS` stays 1):
    - NONE or KEY(other): cnt++. When cnt reaches `DEBOUNCE_FRAMES`, go to IDLE, `KEY_PRESS` = 0.
    - KEY(cand): return to HELD, no new strobe.
- **Release to a different key:** a key pressed during release is only evaluated from IDLE. It needs a full debounce after release completes.
- **`ITEM_CODE` stability:** changes only in the same cycle `KEY_STROBE` fires.

## Timing
- **Reset:** `RESET_N` low asynchronously sets:
  - `COL` = 4'b1110
  - `ITEM_CODE` = 4'h0, `KEY_PRESS` = 0, `KEY_STROBE` = 0
  - FSM in IDLE; all counters and synchroniser flops = 0
  - Scanning starts at column 0 on the first `CLK` edge after deassertion.
- **Reset mid-operation:** any state returns to IDLE. A key still held after deassertion needs a full `DEBOUNCE_FRAMES` again.
- **Frame length:** 4×`SCAN_CYCLES` cycles.
- **Press latency:** `KEY_PRESS`/`KEY_STROBE`/`ITEM_CODE` update on the edge after the frame-resolve cycle of the `DEBOUNCE_FRAMES`-th matching frame.
- **Release latency:** symmetric with press latency.
- **Outputs:** all registered, no combinational path from `ROW` to any output.
- **`KEY_STROBE`:** exactly one cycle wide. Never reasserts without an intervening return to IDLE.
- **`SCAN_CYCLES` below 4:** illegal, caught by an elaboration-time check.

## Configuration
- **`KEYPAD_MULTIKEY_REJECT_EN` defined:**
  - A MULTI frame is treated as NONE.
  - Chorded presses never produce `KEY_PRESS`.
  - A MULTI frame while HELD counts toward release.
- **Not defined:** a MULTI frame resolves to KEY of the first position in scan order (lowest column, then lowest row).

## Structure
- **Shared package `vending_pkg`:**
  - keymap constant (16×4-bit, indexed {col, row})
  - debounce state enum (IDLE, PRESS_PEND, HELD, RELEASE_PEND)
- **Sub-module `keypad_col_scan`:**
  - owns the dwell counter, `col_idx`, `COL` drive and row synchroniser
  - emits a one-cycle `frame_done` with the 16-bit position vector
- **Top:** frame resolution, debounce FSM and output registers.

## Test plan
All scenarios use `SCAN_CYCLES` = 8 (32-cycle frame) and `DEBOUNCE_FRAMES` = 3.
1. **Reset:** pull `RESET_N` low mid-dwell of column 2 → immediately `COL` = 4'b1110, `KEY_PRESS` = 0, `ITEM_CODE` = 4'h0, `KEY_STROBE` = 0. `COL` then cycles 1110→1101→1011→0111 every 8 cycles.
2. **Clean press:** hold key at column 1, row 1 for 10 frames → one `KEY_STROBE`, `ITEM_CODE` = 4'h5, `KEY_PRESS` rises 1 cycle after the 3rd full-frame resolve. After release, `KEY_PRESS` falls 1 cycle after the 3rd empty-frame resolve; `ITEM_CODE` stays 4'h5.
3. **Bounce:** key 7 present/absent/present/absent, then stable → no `KEY_PRESS` until 3 consecutive present frames; exactly one strobe.
4. **Held glitch:** key 0 held, one empty frame inserted → `KEY_PRESS` stays 1, no second strobe.
5. **Chord:** keys 1 and 2 held together for 6 frames:
   - with `KEYPAD_MULTIKEY_REJECT_EN`: `KEY_PRESS` stays 0
   - without it: `ITEM_CODE` = 4'h1, `KEY_PRESS` = 1
6. **Reset in HELD:** assert `RESET_N` low while key A is held → outputs clear asynchronously. With A still held after deassertion, `KEY_PRESS` reasserts only after 3 full frames, `ITEM_CODE` = 4'hA.
